// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding and FDA delay-word field layout for the PLL lock sequencer
package pll_seq_pkg;
    typedef enum logic [2:0] {IDLE, RST, WAIT_LOCK, STABLE, RUN, FAIL} state_t;
    localparam int FDA_NIB_W = 4;
    localparam int FDA_W = 2 * FDA_NIB_W;
    localparam int FDA_FB_LSB = FDA_NIB_W;
    localparam int FDA_REL_LSB = 0;
endpackage

// File: rtl/pll_lock_sequencer_if.sv
// pll_lock_sequencer_if: valid/ready channel carrying DYNAMICDELAY updates into the sequencer
interface pll_lock_sequencer_if;
    import pll_seq_pkg::*;
    logic delay_valid;
    logic [FDA_W-1:0] delay_data;
    logic delay_ready;
    modport master (output delay_valid, output delay_data, input delay_ready);
    modport slave (input delay_valid, input delay_data, output delay_ready);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit, clearing to 0 on rst
module sync_2ff (
    input logic clk,
    input logic rst,
    input logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q <= 1'b0;
        end else begin
            meta <= d;
            q <= meta;
        end
    end
endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: reset/lock/qualify sequencing with timeout, retry and delay updates for an SB_PLL40_2F_PAD
module pll_lock_sequencer import pll_seq_pkg::*; #(
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE = 256,
    parameter int MAX_RETRIES = 3,
    parameter logic [FDA_W-1:0] DELAY_INIT = 8'h00,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst,
    input logic en,
    pll_lock_sequencer_if.slave dif,
    input logic LOCK,
    output logic RESETB,
    output logic BYPASS,
    output logic [FDA_W-1:0] DYNAMICDELAY,
    output logic pll_ready,
    output logic fail,
    output logic lock_lost,
    output logic [1:0] retry_cnt
);
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0] retry_n, retry_inc;
    logic [FDA_W-1:0] dly_n;
    logic lock_s, accept, lost_n, ready_q;

    sync_2ff u_sync (.clk(clk), .rst(rst), .d(LOCK), .q(lock_s));

    assign dif.delay_ready = ready_q;
    assign accept = dif.delay_valid & ready_q;
    assign retry_inc = (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;

    always_comb begin
        state_n = state;
        retry_n = retry_cnt;
        lost_n = 1'b0;
        dly_n = accept ? dif.delay_data : DYNAMICDELAY;
        if (!en) begin
            state_n = IDLE;
            retry_n = 2'd0;
        end else begin
            case (state)
                IDLE: state_n = RST;
                RST: state_n = (cnt == '0) ? WAIT_LOCK : RST;
                WAIT_LOCK: begin
                    // a lock seen on the timeout cycle still wins
                    if (lock_s) state_n = STABLE;
                    else if (cnt == '0) begin
                        retry_n = retry_inc;
                        state_n = (32'(retry_inc) >= MAX_RETRIES) ? FAIL : RST;
                    end
                end
                STABLE: begin
                    if (!lock_s) state_n = WAIT_LOCK;
                    else if (cnt == '0) begin
                        state_n = RUN;
                        retry_n = 2'd0;
                    end
                end
                RUN: begin
                    state_n = (accept || !lock_s) ? RST : RUN;
                    lost_n = !accept && !lock_s;
                end
                FAIL: state_n = FAIL;
                default: state_n = IDLE;
            endcase
        end
        cnt_n = (cnt == '0) ? cnt : cnt - 1'b1;
        if (state_n != state)
            cnt_n = (state_n == RST) ? CNT_W'(RESET_CYCLES - 1) :
                    (state_n == WAIT_LOCK) ? CNT_W'(LOCK_TIMEOUT - 1) :
                    (state_n == STABLE) ? CNT_W'(LOCK_STABLE - 1) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            retry_cnt <= 2'd0;
            RESETB <= 1'b0;
            BYPASS <= 1'b0;
            DYNAMICDELAY <= DELAY_INIT;
            pll_ready <= 1'b0;
            fail <= 1'b0;
            lock_lost <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            retry_cnt <= retry_n;
            RESETB <= state_n inside {WAIT_LOCK, STABLE, RUN};
            BYPASS <= state_n == FAIL;
            DYNAMICDELAY <= dly_n;
            pll_ready <= state_n == RUN;
            fail <= state_n == FAIL;
            lock_lost <= lost_n;
            ready_q <= state_n inside {IDLE, RUN};
        end
    end
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed scenario bench for the PLL lock sequencer with hand-derived cycle counts
module tb_pll_lock_sequencer;
    import pll_seq_pkg::*;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, LOCK = 1'b0;
    logic RESETB, BYPASS, pll_ready, fail, lock_lost;
    logic [FDA_W-1:0] DYNAMICDELAY;
    logic [1:0] retry_cnt;
    int vectors = 0, miscompares = 0, lost_seen = 0;

    pll_lock_sequencer_if dif();

    pll_lock_sequencer #(
        .RESET_CYCLES(4), .LOCK_TIMEOUT(20), .LOCK_STABLE(8), .MAX_RETRIES(2),
        .DELAY_INIT(8'h00), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .dif(dif), .LOCK(LOCK),
        .RESETB(RESETB), .BYPASS(BYPASS), .DYNAMICDELAY(DYNAMICDELAY),
        .pll_ready(pll_ready), .fail(fail), .lock_lost(lock_lost), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (lock_lost === 1'b1) lost_seen++;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic measure(input logic v, output int n);
        n = 0;
        while (RESETB === v && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (pll_ready !== 1'b1 && n < 100);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; LOCK = 1'b0;
        dif.delay_valid = 1'b0; dif.delay_data = '0;
        step(); step();
        vectors++; if ({RESETB, BYPASS, pll_ready, fail, lock_lost, dif.delay_ready} !== 6'b0) begin miscompares++; $display("FAIL reset_flags: got %b want 000000", {RESETB, BYPASS, pll_ready, fail, lock_lost, dif.delay_ready}); end
        vectors++; if (DYNAMICDELAY !== 8'h00) begin miscompares++; $display("FAIL reset_delay: got %h want 00", DYNAMICDELAY); end
        vectors++; if (retry_cnt !== 2'd0) begin miscompares++; $display("FAIL reset_retry: got %0d want 0", retry_cnt); end
        rst = 1'b0;
        step();
        vectors++; if (dif.delay_ready !== 1'b1 || RESETB !== 1'b0) begin miscompares++; $display("FAIL idle_outputs: got ready=%b resetb=%b want 1 0", dif.delay_ready, RESETB); end
    endtask

    task automatic test_lock_seq();
        int n;
        en = 1'b1;
        step();
        measure(1'b0, n);
        vectors++; if (n != 4) begin miscompares++; $display("FAIL first_reset_len: got %0d want 4", n); end
        repeat (3) step();
        LOCK = 1'b1;
        wait_ready(n);
        vectors++; if (n != 11) begin miscompares++; $display("FAIL first_lock_latency: got %0d want 11", n); end
        vectors++; if (retry_cnt !== 2'd0 || RESETB !== 1'b1) begin miscompares++; $display("FAIL first_lock_state: got retry=%0d resetb=%b want 0 1", retry_cnt, RESETB); end
    endtask

    task automatic test_lock_lost();
        int n;
        lost_seen = 0;
        LOCK = 1'b0;
        step(); step(); step();
        vectors++; if (lock_lost !== 1'b1 || pll_ready !== 1'b0) begin miscompares++; $display("FAIL lost_pulse: got lost=%b ready=%b want 1 0", lock_lost, pll_ready); end
        LOCK = 1'b1;
        measure(1'b0, n);
        vectors++; if (n != 4) begin miscompares++; $display("FAIL lost_reset_len: got %0d want 4", n); end
        wait_ready(n);
        vectors++; if (n != 9) begin miscompares++; $display("FAIL relock_latency: got %0d want 9", n); end
        vectors++; if (lost_seen != 1) begin miscompares++; $display("FAIL lost_pulse_count: got %0d want 1", lost_seen); end
    endtask

    task automatic test_stable_glitch();
        int n;
        LOCK = 1'b0; en = 1'b0;
        step();
        en = 1'b1;
        n = 0;
        do begin step(); n++; end while (retry_cnt !== 2'd1 && n < 100);
        vectors++; if (retry_cnt !== 2'd1) begin miscompares++; $display("FAIL glitch_first_timeout: got %0d want 1", retry_cnt); end
        n = 0;
        while (RESETB !== 1'b1 && n < 100) begin step(); n++; end
        LOCK = 1'b1;
        repeat (6) step();
        LOCK = 1'b0;
        step();
        LOCK = 1'b1;
        repeat (10) step();
        vectors++; if (pll_ready !== 1'b0 || retry_cnt !== 2'd1) begin miscompares++; $display("FAIL glitch_requalify: got ready=%b retry=%0d want 0 1", pll_ready, retry_cnt); end
        step();
        vectors++; if (pll_ready !== 1'b1 || retry_cnt !== 2'd0) begin miscompares++; $display("FAIL glitch_ready: got ready=%b retry=%0d want 1 0", pll_ready, retry_cnt); end
    endtask

    task automatic test_delay();
        int n;
        logic [FDA_W-1:0] dd;
        lost_seen = 0;
        vectors++; if (dif.delay_ready !== 1'b1) begin miscompares++; $display("FAIL run_ready: got %b want 1", dif.delay_ready); end
        dd = '0;
        dd[FDA_FB_LSB +: FDA_NIB_W] = 4'hA;
        dd[FDA_REL_LSB +: FDA_NIB_W] = 4'h5;
        dif.delay_data = dd; dif.delay_valid = 1'b1;
        step();
        vectors++; if (DYNAMICDELAY !== 8'hA5) begin miscompares++; $display("FAIL accept_data: got %h want a5", DYNAMICDELAY); end
        vectors++; if ({pll_ready, dif.delay_ready, RESETB, lock_lost} !== 4'b0) begin miscompares++; $display("FAIL accept_relock: got %b want 0000", {pll_ready, dif.delay_ready, RESETB, lock_lost}); end
        dif.delay_data = 8'h3C;
        repeat (5) step();
        vectors++; if (DYNAMICDELAY !== 8'hA5) begin miscompares++; $display("FAIL offer_held: got %h want a5", DYNAMICDELAY); end
        wait_ready(n);
        vectors++; if (n != 8 || dif.delay_ready !== 1'b1 || DYNAMICDELAY !== 8'hA5) begin miscompares++; $display("FAIL delay_relock: got n=%0d ready=%b dly=%h want 8 1 a5", n, dif.delay_ready, DYNAMICDELAY); end
        step();
        vectors++; if (DYNAMICDELAY !== 8'h3C || pll_ready !== 1'b0) begin miscompares++; $display("FAIL second_accept: got dly=%h ready=%b want 3c 0", DYNAMICDELAY, pll_ready); end
        dif.delay_valid = 1'b0;
        wait_ready(n);
        vectors++; if (n != 13) begin miscompares++; $display("FAIL accept_relock_latency: got %0d want 13", n); end
        vectors++; if (lost_seen != 0) begin miscompares++; $display("FAIL accept_no_lost: got %0d want 0", lost_seen); end
    endtask

    task automatic test_timeout_fail();
        int n;
        en = 1'b0; LOCK = 1'b0;
        step();
        en = 1'b1;
        step();
        measure(1'b0, n);
        vectors++; if (n != 4) begin miscompares++; $display("FAIL to_reset1: got %0d want 4", n); end
        measure(1'b1, n);
        vectors++; if (n != 20) begin miscompares++; $display("FAIL to_wait1: got %0d want 20", n); end
        vectors++; if (retry_cnt !== 2'd1) begin miscompares++; $display("FAIL to_retry1: got %0d want 1", retry_cnt); end
        measure(1'b0, n);
        vectors++; if (n != 4) begin miscompares++; $display("FAIL to_reset2: got %0d want 4", n); end
        measure(1'b1, n);
        vectors++; if (n != 20) begin miscompares++; $display("FAIL to_wait2: got %0d want 20", n); end
        vectors++; if ({fail, BYPASS, RESETB} !== 3'b110 || retry_cnt !== 2'd2) begin miscompares++; $display("FAIL to_fail_state: got fbr=%b retry=%0d want 110 2", {fail, BYPASS, RESETB}, retry_cnt); end
    endtask

    task automatic test_en();
        int n;
        en = 1'b0;
        step();
        en = 1'b1;
        n = 0;
        while (RESETB !== 1'b1 && n < 100) begin step(); n++; end
        repeat (3) step();
        en = 1'b0;
        step();
        vectors++; if ({RESETB, dif.delay_ready, pll_ready} !== 3'b010 || retry_cnt !== 2'd0) begin miscompares++; $display("FAIL en_off_wait: got rrp=%b retry=%0d want 010 0", {RESETB, dif.delay_ready, pll_ready}, retry_cnt); end
        en = 1'b1;
        n = 0;
        while (fail !== 1'b1 && n < 200) begin step(); n++; end
        repeat (3) step();
        vectors++; if (fail !== 1'b1 || BYPASS !== 1'b1) begin miscompares++; $display("FAIL fail_held: got fail=%b bypass=%b want 1 1", fail, BYPASS); end
        en = 1'b0;
        step();
        vectors++; if ({fail, BYPASS, dif.delay_ready} !== 3'b001 || retry_cnt !== 2'd0) begin miscompares++; $display("FAIL en_off_fail: got fbr=%b retry=%0d want 001 0", {fail, BYPASS, dif.delay_ready}, retry_cnt); end
        vectors++; if (DYNAMICDELAY !== 8'h3C) begin miscompares++; $display("FAIL en_off_delay: got %h want 3c", DYNAMICDELAY); end
        en = 1'b1;
        step();
        vectors++; if ({RESETB, dif.delay_ready, fail} !== 3'b000 || retry_cnt !== 2'd0) begin miscompares++; $display("FAIL restart: got rrf=%b retry=%0d want 000 0", {RESETB, dif.delay_ready, fail}, retry_cnt); end
        measure(1'b0, n);
        vectors++; if (n != 4) begin miscompares++; $display("FAIL restart_reset_len: got %0d want 4", n); end
        LOCK = 1'b1;
        wait_ready(n);
        vectors++; if (n != 11) begin miscompares++; $display("FAIL restart_lock_latency: got %0d want 11", n); end
        rst = 1'b1;
        step();
        vectors++; if ({RESETB, BYPASS, pll_ready, fail, lock_lost, dif.delay_ready} !== 6'b0 || retry_cnt !== 2'd0) begin miscompares++; $display("FAIL rst_run_flags: got %b retry=%0d want 000000 0", {RESETB, BYPASS, pll_ready, fail, lock_lost, dif.delay_ready}, retry_cnt); end
        vectors++; if (DYNAMICDELAY !== 8'h00) begin miscompares++; $display("FAIL rst_run_delay: got %h want 00", DYNAMICDELAY); end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock_seq();
        test_lock_lost();
        test_stable_glitch();
        test_delay();
        test_timeout_fail();
        test_en();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
